// File: rtl/ct_f_spsram_1024x92_ctrl.sv
// Request/response front-end for the 1024x92 single-port SRAM: zero-fills the array
// after reset, then maps a valid/ready request stream onto the SRAM pins and buffers read data.
module ct_f_spsram_1024x92_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 92,
    parameter int unsigned SEG_WIDTH  = 23,
    parameter int unsigned INIT_EN    = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int unsigned NUM_SEG = 4;

    if (DATA_WIDTH != NUM_SEG * SEG_WIDTH) begin : g_bad_cfg
        $error("DATA_WIDTH must equal 4*SEG_WIDTH");
    end

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   buf_q [2];

    logic                    fill_last;
    logic                    fill_active;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic                    accept;
    logic [2:0]              occupancy;
    logic [DATA_WIDTH-1:0]   wmask_bits;

    // Per-bit write enable (active high) expanded from the segment mask.
    for (genvar k = 0; k < NUM_SEG; k++) begin : g_wmask
        assign wmask_bits[k*SEG_WIDTH +: SEG_WIDTH] = {SEG_WIDTH{req_wmask[k]}};
    end

    assign fill_last   = (fill_cnt_q == {ADDR_WIDTH{1'b1}});
    // Gated by reset so the SRAM is never enabled while reset is held.
    assign fill_active = (state_q == ST_INIT) && (INIT_EN != 0) && cpurst_b;

    assign push      = rd_pend_q;
    assign pop       = rsp_vld & rsp_rdy;
    // A read accepted now needs a slot when its data lands next cycle.
    assign occupancy = 3'(count_q) + 3'(rd_pend_q) - 3'(pop);
    assign credit_ok = (occupancy < 3'd2);

    assign rsp_vld   = (count_q != 2'd0);
    assign rsp_data  = buf_q[rd_ptr_q];
    assign init_done = init_done_q;

    // FSM state register.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if ((INIT_EN == 0) || fill_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs: SRAM pin drive and request handshake.
    always_comb begin
        req_rdy   = 1'b0;
        accept    = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (fill_active) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = '0;
            sram_a    = fill_cnt_q;
        end else if (state_q == ST_RUN) begin
            req_rdy = credit_ok;
            accept  = req_vld & credit_ok;
            if (accept) begin
                sram_cen = 1'b0;
                if (req_wr) begin
                    sram_gwen = 1'b0;
                    sram_wen  = ~wmask_bits;
                end
            end
        end
    end

    // Fill counter, read tracking and response FIFO bookkeeping.
    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        init_done_d = init_done_q;
        if ((state_q == ST_INIT) && (INIT_EN != 0)) begin
            fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
        end
        if ((state_q == ST_INIT) && (state_d == ST_RUN)) begin
            init_done_d = 1'b1;
        end
        rd_pend_d = accept & ~req_wr;
        count_d   = count_q + 2'(push) - 2'(pop);
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            fill_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            init_done_q <= init_done_d;
            rd_pend_q   <= rd_pend_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Read data from the SRAM is captured one cycle after the read is issued.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (push) begin
            buf_q[wr_ptr_q] <= sram_q;
        end
    end

    a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        push |-> (count_q != 2'd2));

endmodule

// File: tb/tb_ct_f_spsram_1024x92_ctrl.sv
// Directed bench for ct_f_spsram_1024x92_ctrl with a behavioural SRAM and a
// queue-based response scoreboard.
module tb_ct_f_spsram_1024x92_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [9:0]  req_addr;
    logic [91:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [91:0] rsp_data;
    logic        init_done;
    logic [9:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [91:0] sram_wen;
    logic [91:0] sram_d;
    logic [91:0] sram_q;

    int n_checks = 0;
    int n_fail   = 0;

    ct_f_spsram_1024x92_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_data       (rsp_data),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM, seeded with garbage so the zero-fill is observable.
    logic [91:0] mem [1024];
    logic        seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= {4{23'h5A5A5A}} ^ 92'(i + 1);
            end
            seeded <= 1'b1;
        end else if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    task automatic check(input string name, input logic [91:0] got, input logic [91:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: expected read data pushed at accept, popped on every response transfer.
    logic [91:0] exp_q [$];
    logic [91:0] mon_exp;
    logic [91:0] data_prev;
    logic        stall_prev = 1'b0;
    int          rsp_seen    = 0;
    int          vld_run     = 0;
    int          vld_run_max = 0;

    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            vld_run    = 0;
            stall_prev = 1'b0;
        end else begin
            if (rsp_vld) vld_run++;
            else         vld_run = 0;
            if (vld_run > vld_run_max) vld_run_max = vld_run;
            if (rsp_vld && stall_prev) check("rsp_data_hold", rsp_data, data_prev);
            if (rsp_vld && rsp_rdy) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rsp_data", rsp_data, mon_exp);
                end
            end
            stall_prev = rsp_vld && !rsp_rdy;
            data_prev  = rsp_data;
        end
    end

    task automatic req_idle();
        req_vld = 1'b0;
        req_wr  = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic do_req(input logic wr, input logic [9:0] addr, input logic [91:0] data,
                          input logic [3:0] mask, input logic [91:0] exp, output int stalls);
        int waited;
        waited    = 0;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        #1;
        while (!req_rdy && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        stalls = waited;
        if (!req_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got req_rdy=0 for %0d cycles expected acceptance", waited);
            req_idle();
        end else begin
            if (!wr) exp_q.push_back(exp);
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rsp_vld) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || rsp_vld) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: got %0d responses outstanding expected 0", name, exp_q.size());
        end
    endtask

    // Counts cycles whose pins match a zero-fill write of the expected address.
    task automatic fill_cycles(input int n, output int good);
        good = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (sram_cen == 1'b0 && sram_gwen == 1'b0 && sram_wen == '0 && sram_d == '0 &&
                sram_a == 10'(i) && !req_rdy && !init_done && !rsp_vld) good++;
            @(negedge clk);
        end
    endtask

    localparam logic [91:0] ONES = {92{1'b1}};
    localparam logic [91:0] D1   = {4{23'h0ABCD1}};
    localparam logic [91:0] D2   = {4{23'h13579B}};
    localparam logic [91:0] D3   = {4{23'h2468AC}};
    localparam logic [91:0] D4   = {4{23'h7F00F4}};

    initial begin
        int st;
        int tot;
        int good;
        int nz;
        int seen0;
        logic [91:0] pat [4];
        pat[0] = D1; pat[1] = D2; pat[2] = D3; pat[3] = D4;

        rst_n     = 1'b0;
        rsp_rdy   = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        req_idle();

        repeat (3) @(negedge clk);
        #1;
        check1("rst_req_rdy",   req_rdy,   1'b0);
        check1("rst_rsp_vld",   rsp_vld,   1'b0);
        check1("rst_init_done", init_done, 1'b0);
        check1("rst_sram_cen",  sram_cen,  1'b1);
        check1("rst_sram_gwen", sram_gwen, 1'b1);
        check("rst_sram_wen",   sram_wen,  ONES);

        // Zero-fill: 1024 write cycles, init_done in the following cycle.
        @(negedge clk);
        rst_n = 1'b1;
        fill_cycles(1024, good);
        check_int("fill_cycles", good, 1024);
        #1;
        check1("fill_init_done", init_done, 1'b1);
        check1("fill_cen_idle",  sram_cen,  1'b1);
        check1("fill_req_rdy",   req_rdy,   1'b1);
        nz = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] != '0) nz++;
        check_int("fill_nonzero_words", nz, 0);
        @(negedge clk);

        do_req(1'b0, 10'h3FF, '0, 4'h0, 92'h0, st);
        req_idle();
        drain("rd_3ff");

        // Full write then immediate read: new data, 2-cycle latency.
        do_req(1'b1, 10'h155, ONES, 4'hF, '0, st);
        do_req(1'b0, 10'h155, '0, 4'h0, ONES, st);
        req_idle();
        check1("rd_lat_t1", rsp_vld, 1'b0);
        @(negedge clk);
        check1("rd_lat_t2", rsp_vld, 1'b1);
        drain("wr_rd_155");

        // Segment masks: bits 0 and 2 cleared, zero mask leaves the word alone.
        do_req(1'b1, 10'd5, ONES, 4'hF, '0, st);
        do_req(1'b1, 10'd5, '0, 4'b0101, '0, st);
        do_req(1'b1, 10'd5, '0, 4'b0000, '0, st);
        do_req(1'b0, 10'd5, '0, 4'h0, {23'h7FFFFF, 23'h0, 23'h7FFFFF, 23'h0}, st);
        req_idle();
        drain("mask");

        for (int i = 0; i < 4; i++) do_req(1'b1, 10'(i + 1), pat[i], 4'hF, '0, st);
        req_idle();

        // Back-pressure: two reads fit, the third waits for a pop.
        rsp_rdy = 1'b0;
        seen0 = rsp_seen;
        do_req(1'b0, 10'd1, '0, 4'h0, D1, st);
        check_int("bp_rd1_stall", st, 0);
        do_req(1'b0, 10'd2, '0, 4'h0, D2, st);
        check_int("bp_rd2_stall", st, 0);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 10'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check1("bp_rdy_low", req_rdy, 1'b0);
            @(negedge clk);
        end
        check1("bp_rsp_vld", rsp_vld, 1'b1);
        rsp_rdy = 1'b1;
        do_req(1'b0, 10'd3, '0, 4'h0, D3, st);
        do_req(1'b0, 10'd4, '0, 4'h0, D4, st);
        req_idle();
        drain("bp");
        check_int("bp_rsp_count", rsp_seen - seen0, 4);

        // Streaming: eight back-to-back reads with the consumer always ready.
        vld_run_max = 0;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 10'((i % 4) + 1), '0, 4'h0, pat[i % 4], st);
            tot += st;
        end
        req_idle();
        drain("stream");
        check_int("stream_stalls", tot, 0);
        check_int("stream_vld_run", vld_run_max, 8);

        // Reset with one buffered response, then again part-way through the fill.
        rsp_rdy = 1'b0;
        do_req(1'b0, 10'h155, '0, 4'h0, ONES, st);
        req_idle();
        @(negedge clk);
        check1("rr_buffered", rsp_vld, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check1("rr_rsp_vld", rsp_vld,   1'b0);
        check1("rr_cen",     sram_cen,  1'b1);
        check1("rr_req_rdy", req_rdy,   1'b0);
        check1("rr_done",    init_done, 1'b0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        fill_cycles(300, good);
        check_int("refill_head", good, 300);
        #1;
        check("fill_addr_300", 92'(sram_a), 92'd300);
        rst_n = 1'b0;
        #1;
        check1("rr2_cen", sram_cen, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        fill_cycles(1024, good);
        check_int("refill_full", good, 1024);
        #1;
        check1("refill_done", init_done, 1'b1);
        @(negedge clk);
        do_req(1'b0, 10'h155, '0, 4'h0, 92'h0, st);
        req_idle();
        drain("post_reset");
        check_int("post_reset_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

endmodule
